dram_responder: RTL and testbench
=================================

Name: dram_responder

Overview:
- Memory-side responder for the MCU's external DRAM request interface.
- Accepts the single-cycle read and write strobes issued by mem_controller. Services them from an internal word-addressed RAM with programmable wait states. Returns a one-cycle dram_ack.
- Used as the DRAM stand-in on boards without SDRAM and as the bench model for the MCU top.

Parameters:
- XLEN, 32, data word width.
- ADDR_BITS, 16, request address width in words; matches MEM_ADDR_BITS.
- DEPTH_BITS, 12, log2 of the backing RAM depth in words; must be <= ADDR_BITS.
- READ_LATENCY, 4, cycles from read strobe to ack; must be >= 1.
- WRITE_LATENCY, 2, cycles from write strobe to ack; must be >= 1.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- sync_reset  in  1  synchronous reset, active high; same effect as reset_n.
- mem_addr  in  ADDR_BITS  word address; sampled on a strobe.
- mem_read_en  in  1  read strobe, one cycle.
- mem_write_en  in  1  write strobe, one cycle.
- mem_byte_enable  in  XLEN/8  byte lanes for a write; bit i selects bits 8i+7:8i.
- mem_write_data  in  XLEN  write data; sampled on the strobe.
- ack  out  1  one-cycle completion pulse for reads and writes.
- read_data  out  XLEN  read result; valid in the ack cycle and held until the next read ack.
- busy  out  1  high while a request is outstanding.
- protocol_err  out  1  sticky; set on a dropped or conflicting request.
- range_err  out  1  sticky; set on an out-of-range address.

Behaviour:
- Reset (reset_n low, asynchronous; or sync_reset high at an edge):
  - ack=0, read_data=0, busy=0, protocol_err=0, range_err=0, FSM to IDLE.
  - A request in flight is discarded and never acked.
  - RAM contents are not cleared.
- FSM states: IDLE, WAIT, ACK.
  - IDLE: on a strobe at edge T, latch addr/data/byte_enable/type, load counter with LATENCY-1, set busy=1.
    - LATENCY==1: go to ACK.
    - Otherwise: go to WAIT.
  - WAIT: decrement the counter each cycle; at 1, go to ACK.
  - ACK: ack=1 for exactly one cycle; busy drops in the same cycle; go to IDLE.
- Latency: a strobe sampled at edge T gives ack high during cycle T+LATENCY.
  - A new strobe is accepted in the cycle after ack (back-to-back throughput = LATENCY+1 cycles).
- Write:
  - RAM is updated at the edge that enters ACK.
  - Only enabled byte lanes change.
  - byte_enable = 0 still acks and changes nothing.
- Read:
  - The RAM word is registered into read_data at the edge that enters ACK.
  - A read always returns the latest completed write.
- Range: mem_addr bits ADDR_BITS-1:DEPTH_BITS nonzero sets range_err.
  - Write: ignored.
  - Read: returns 0.
  - Both still ack at normal latency.
- mem_read_en and mem_write_en high in the same cycle: treated as a write; protocol_err set.
- Strobe while busy=1 (including the ACK cycle): dropped; protocol_err set; the in-flight request is unaffected.
- Strobe held high for several cycles: each cycle counts as a strobe, so cycles after the first are dropped and set protocol_err.
- RAM: single-port, inferred as block RAM; one access per request.

Test Plan:
1. Reset, write addr 0x0010 data 0xDEADBEEF be=4'hF, then read 0x0010 -> write ack at T+2, read ack at T+4, read_data=0xDEADBEEF; protocol_err=0, range_err=0.
2. Preload 0x11223344 at 0x0020, write be=4'b0101 data 0xAABBCCDD, then read -> 0x11BB33DD.
3. Read strobe, then a second read strobe 2 cycles later -> only one ack; protocol_err=1; first read data correct.
4. Read and write strobes both high, addr 0x0005 data 0x5 -> acked as a write; protocol_err=1; a later read of 0x0005 returns 0x5.
5. DEPTH_BITS=12, read addr 0x1000 -> ack at T+4, read_data=0, range_err=1; a prior write to 0x1000 does not alias to 0x0000.
6. Read strobe, then assert reset_n low at T+2 -> ack, busy and read_data go to 0 immediately; no ack after release; RAM word at 0x0010 still returns 0xDEADBEEF on a later read.

Source files
------------

// File: rtl/dram_responder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : dram_responder
// Brief    : Word-addressed RAM responder for the MCU DRAM strobe interface,
//            with programmable read/write wait states and a one-cycle ack.
// Revision : 1.0
// ============================================================================

module dram_responder #(
  parameter int XLEN          = 32,
  parameter int ADDR_BITS     = 16,
  parameter int DEPTH_BITS    = 12,
  parameter int READ_LATENCY  = 4,
  parameter int WRITE_LATENCY = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 sync_reset,
  input  logic [ADDR_BITS-1:0] mem_addr,
  input  logic                 mem_read_en,
  input  logic                 mem_write_en,
  input  logic [XLEN/8-1:0]    mem_byte_enable,
  input  logic [XLEN-1:0]      mem_write_data,
  output logic                 ack,
  output logic [XLEN-1:0]      read_data,
  output logic                 busy,
  output logic                 protocol_err,
  output logic                 range_err
);

  localparam int NB      = XLEN / 8;
  localparam int DEPTH   = 1 << DEPTH_BITS;
  localparam int MAX_LAT = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(READ_LATENCY - 1);
  localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WRITE_LATENCY - 1);
  localparam logic             RD_LAT1 = (READ_LATENCY == 1);
  localparam logic             WR_LAT1 = (WRITE_LATENCY == 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_ACK  = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DEPTH_BITS-1:0] addr_q;
  logic [NB-1:0]         be_q;
  logic [XLEN-1:0]       wdata_q;
  logic                  wr_q;
  logic                  oob_q;
  logic                  perr_q;
  logic                  rerr_q;
  logic                  rd_sel_q;
  logic [XLEN-1:0]       ram_rd_q;
  logic [XLEN-1:0]       ram_q [DEPTH];

  logic                  w_strobe;
  logic                  w_idle;
  logic                  w_accept;
  logic                  w_drop;
  logic                  w_conflict;
  logic                  w_req_oob;
  logic                  w_req_lat1;
  logic                  w_enter_ack;
  logic                  w_acc_wr;
  logic                  w_acc_oob;
  logic [DEPTH_BITS-1:0] w_acc_idx;
  logic [NB-1:0]         w_acc_be;
  logic [XLEN-1:0]       w_acc_data;
  logic                  w_ram_we;
  logic                  w_ram_re;

  generate
    if (DEPTH_BITS < ADDR_BITS) begin : g_range_chk
      assign w_req_oob = |mem_addr[ADDR_BITS-1:DEPTH_BITS];
    end else begin : g_full_range
      assign w_req_oob = 1'b0;
    end
  endgenerate

  assign w_strobe   = mem_read_en | mem_write_en;
  assign w_conflict = mem_read_en & mem_write_en;
  assign w_idle     = (state_q == S_IDLE);
  assign w_accept   = w_idle & w_strobe;
  assign w_drop     = ~w_idle & w_strobe;
  assign w_req_lat1 = mem_write_en ? WR_LAT1 : RD_LAT1;

  // A latency-1 request reaches ACK on its own strobe edge, so the RAM
  // access must come straight from the ports rather than the latched copy.
  assign w_acc_wr   = w_idle ? mem_write_en : wr_q;
  assign w_acc_oob  = w_idle ? w_req_oob : oob_q;
  assign w_acc_idx  = w_idle ? mem_addr[DEPTH_BITS-1:0] : addr_q;
  assign w_acc_be   = w_idle ? mem_byte_enable : be_q;
  assign w_acc_data = w_idle ? mem_write_data : wdata_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    w_enter_ack = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (w_accept) begin
          cnt_d = mem_write_en ? WR_LOAD : RD_LOAD;
          if (w_req_lat1) begin
            state_d     = S_ACK;
            w_enter_ack = 1'b1;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d     = S_ACK;
          w_enter_ack = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign w_ram_we = w_enter_ack & w_acc_wr & ~w_acc_oob & reset_n & ~sync_reset;
  assign w_ram_re = w_enter_ack & ~w_acc_wr & ~w_acc_oob;

  // Backing store kept free of resets so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (w_ram_we) begin
      for (int b = 0; b < NB; b++) begin
        if (w_acc_be[b]) begin
          ram_q[w_acc_idx][8*b +: 8] <= w_acc_data[8*b +: 8];
        end
      end
    end
    if (w_ram_re) begin
      ram_rd_q <= ram_q[w_acc_idx];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      be_q     <= '0;
      wdata_q  <= '0;
      wr_q     <= 1'b0;
      oob_q    <= 1'b0;
      perr_q   <= 1'b0;
      rerr_q   <= 1'b0;
      rd_sel_q <= 1'b0;
    end else if (sync_reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      be_q     <= '0;
      wdata_q  <= '0;
      wr_q     <= 1'b0;
      oob_q    <= 1'b0;
      perr_q   <= 1'b0;
      rerr_q   <= 1'b0;
      rd_sel_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (w_accept) begin
        addr_q  <= mem_addr[DEPTH_BITS-1:0];
        be_q    <= mem_byte_enable;
        wdata_q <= mem_write_data;
        wr_q    <= mem_write_en;
        oob_q   <= w_req_oob;
      end
      if (w_drop | w_conflict) begin
        perr_q <= 1'b1;
      end
      if (w_accept & w_req_oob) begin
        rerr_q <= 1'b1;
      end
      // An out-of-range read forces the visible result to zero until the next read.
      if (w_enter_ack & ~w_acc_wr) begin
        rd_sel_q <= ~w_acc_oob;
      end
    end
  end

  assign ack          = (state_q == S_ACK);
  assign busy         = ~w_idle;
  assign read_data    = rd_sel_q ? ram_rd_q : '0;
  assign protocol_err = perr_q;
  assign range_err    = rerr_q;

endmodule

`default_nettype wire

// File: tb/tb_dram_responder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_dram_responder
// Brief    : Randomised scoreboard bench for dram_responder.
// Revision : 1.0
// ============================================================================

module tb_dram_responder;

  localparam int XLEN = 32;
  localparam int AB   = 16;
  localparam int DB   = 12;
  localparam int RL   = 4;
  localparam int WL   = 2;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            sync_reset;
  logic [AB-1:0]   mem_addr;
  logic            mem_read_en;
  logic            mem_write_en;
  logic [3:0]      mem_byte_enable;
  logic [XLEN-1:0] mem_write_data;
  logic            ack;
  logic [XLEN-1:0] read_data;
  logic            busy;
  logic            protocol_err;
  logic            range_err;

  dram_responder #(
    .XLEN(XLEN), .ADDR_BITS(AB), .DEPTH_BITS(DB),
    .READ_LATENCY(RL), .WRITE_LATENCY(WL)
  ) dut (
    .clk(clk), .reset_n(reset_n), .sync_reset(sync_reset),
    .mem_addr(mem_addr), .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
    .mem_byte_enable(mem_byte_enable), .mem_write_data(mem_write_data),
    .ack(ack), .read_data(read_data), .busy(busy),
    .protocol_err(protocol_err), .range_err(range_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          is_rd;
    logic [31:0] data;
    int          ack_cyc;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] ram_m [logic [15:0]];
  bit          perr_m;
  bit          rerr_m;
  int          next_ok;
  logic [31:0] last_rd_m;
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %h required %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: every ack must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (ack === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_ack: actual ack=1 required ack=0 (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        chk("ack_cycle", 32'(cyc), 32'(e.ack_cyc));
        chk(e.is_rd ? "read_data" : "read_data_hold", read_data, e.data);
      end
    end
  end

  task automatic model_reset();
    sb.delete();
    perr_m    = 1'b0;
    rerr_m    = 1'b0;
    last_rd_m = 32'h0;
    next_ok   = 0;
  endtask

  // Call at a negedge; drives one strobe cycle and updates the reference model.
  task automatic issue(input bit rd, input bit wr, input logic [15:0] a,
                       input logic [3:0] be, input logic [31:0] d);
    int          k;
    int          lat;
    bit          acc;
    bit          oob;
    exp_t        e;
    logic [31:0] w;
    mem_read_en     = rd;
    mem_write_en    = wr;
    mem_addr        = a;
    mem_byte_enable = be;
    mem_write_data  = d;
    @(posedge clk);
    #1;
    k   = cyc;
    acc = (k >= next_ok);
    if (rd && wr) perr_m = 1'b1;
    if (!acc) begin
      perr_m = 1'b1;
    end else begin
      lat     = wr ? WL : RL;
      next_ok = k + lat + 1;
      oob     = (a >> DB) != 16'h0;
      if (oob) rerr_m = 1'b1;
      if (wr) begin
        if (!oob) begin
          w = ram_m.exists(a) ? ram_m[a] : 32'h0;
          for (int b = 0; b < 4; b++)
            if (be[b]) w[8*b +: 8] = d[8*b +: 8];
          ram_m[a] = w;
        end
        e.is_rd = 1'b0;
        e.data  = last_rd_m;
      end else begin
        e.is_rd   = 1'b1;
        e.data    = oob ? 32'h0 : ram_m[a];
        last_rd_m = e.data;
      end
      e.ack_cyc = k + lat - 1;
      sb.push_back(e);
    end
    @(negedge clk);
    mem_read_en  = 1'b0;
    mem_write_en = 1'b0;
    if (acc) chk("busy_after_accept", 32'(busy), 32'd1);
  endtask

  task automatic wait_idle();
    int t = 0;
    while (sb.size() != 0 && t < 60) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL ack_timeout: actual %0d acks missing required 0", sb.size());
      sb.delete();
    end
    @(negedge clk);
    chk("busy_idle", 32'(busy), 32'd0);
  endtask

  task automatic chk_flags();
    chk("protocol_err", 32'(protocol_err), 32'(perr_m));
    chk("range_err", 32'(range_err), 32'(rerr_m));
  endtask

  task automatic pulse_sync_reset();
    sync_reset = 1'b1;
    @(negedge clk);
    sync_reset = 1'b0;
    model_reset();
    chk_flags();
    chk("read_data_sync_rst", read_data, 32'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual simulation still running required finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] ra;
    int          kind;
    reset_n         = 1'b0;
    sync_reset      = 1'b0;
    mem_addr        = '0;
    mem_read_en     = 1'b0;
    mem_write_en    = 1'b0;
    mem_byte_enable = '0;
    mem_write_data  = '0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_read_data", read_data, 32'h0);
    chk("rst_protocol_err", 32'(protocol_err), 32'd0);
    chk("rst_range_err", 32'(range_err), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Basic write then read.
    issue(0, 1, 16'h0010, 4'hF, 32'hDEADBEEF); wait_idle();
    issue(1, 0, 16'h0010, 4'h0, 32'h0);        wait_idle();
    chk_flags();

    // Byte-lane merge, then a zero-enable write that must change nothing.
    issue(0, 1, 16'h0020, 4'hF, 32'h11223344); wait_idle();
    issue(0, 1, 16'h0020, 4'h5, 32'hAABBCCDD); wait_idle();
    issue(1, 0, 16'h0020, 4'h0, 32'h0);        wait_idle();
    chk("merge_model", ram_m[16'h0020], 32'h11BB33DD);
    issue(0, 1, 16'h0020, 4'h0, 32'hFFFFFFFF); wait_idle();
    issue(1, 0, 16'h0020, 4'h0, 32'h0);        wait_idle();

    // Second strobe while busy is dropped.
    issue(1, 0, 16'h0010, 4'h0, 32'h0);
    @(negedge clk);
    issue(1, 0, 16'h0020, 4'h0, 32'h0);
    wait_idle();
    chk_flags();
    pulse_sync_reset();

    // Simultaneous strobes behave as a write.
    issue(1, 1, 16'h0005, 4'hF, 32'h00000005); wait_idle();
    issue(1, 0, 16'h0005, 4'h0, 32'h0);        wait_idle();
    chk_flags();
    pulse_sync_reset();

    // Out-of-range accesses neither alias nor return data.
    issue(0, 1, 16'h0000, 4'hF, 32'h12345678); wait_idle();
    issue(0, 1, 16'h1000, 4'hF, 32'hCAFEF00D); wait_idle();
    issue(1, 0, 16'h0000, 4'h0, 32'h0);        wait_idle();
    issue(1, 0, 16'h1000, 4'h0, 32'h0);        wait_idle();
    chk_flags();
    pulse_sync_reset();

    // Asynchronous reset mid-read discards the request but keeps RAM.
    issue(1, 0, 16'h0020, 4'h0, 32'h0);
    wait_idle();
    issue(1, 0, 16'h0010, 4'h0, 32'h0);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    chk("async_rst_ack", 32'(ack), 32'd0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_read_data", read_data, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (8) @(negedge clk);
    chk_flags();
    issue(1, 0, 16'h0010, 4'h0, 32'h0); wait_idle();

    // Randomised traffic over a preloaded window plus out-of-range hits.
    for (int i = 0; i < 16; i++) begin
      issue(0, 1, 16'h0100 + 16'(i), 4'hF, $urandom); wait_idle();
    end
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 9) == 0)
        ra = {4'($urandom_range(1, 15)), 12'($urandom)};
      else
        ra = 16'h0100 + 16'($urandom_range(0, 15));
      kind = $urandom_range(0, 19);
      if (kind < 9)
        issue(1, 0, ra, 4'($urandom), $urandom);
      else if (kind < 18)
        issue(0, 1, ra, 4'($urandom), $urandom);
      else
        issue(1, 1, ra, 4'($urandom), $urandom);
      repeat ($urandom_range(0, 5)) @(negedge clk);
    end
    wait_idle();
    chk_flags();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
